// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory controller.
// State encoding, access size codes and load/store funct3 values.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_WAIT_RD = 2'b10,
        ST_RESP    = 2'b11
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication,
// alignment check and right-justification of read data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misaligned,
    output logic [31:0] rdata_shift
);

    always_comb begin
        be         = 4'b0000;
        wdata_rep  = wdata;
        misaligned = 1'b0;
        case (size)
            SZ_B: begin
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be         = 4'b0011 << offset;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = offset[0];
            end
            SZ_W: begin
                be         = 4'b1111;
                misaligned = |offset;
            end
            default: misaligned = 1'b1;
        endcase
    end

    assign rdata_shift = rdata >> {offset, 3'b000};

endmodule

// File: rtl/lsu_mem_ctrl.sv
// RV32I MEM-stage load/store controller with req/gnt/rvalid memory port.
// Define LSU_TIMEOUT_EN to enable the TIMEOUT_CYCLES bus watchdog.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] iv_addr,
    input  logic [2:0]  iv_funct3,
    input  logic [31:0] iv_wdata,
    output logic        o_ack,
    output logic        o_load_valid,
    output logic [31:0] ov_load_word,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_busy,
    output logic        o_mem_req,
    output logic [31:0] ov_mem_addr,
    output logic [3:0]  ov_mem_be,
    output logic [31:0] ov_mem_wdata,
    output logic        o_mem_we,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] iv_mem_rdata
);

    state_t      state, state_n;
    logic [31:0] addr_q, wdata_q, load_word_q;
    logic [1:0]  size_q;
    logic        we_q, err_q, to_q;
    logic        timeout_hit, req_on;
    logic [1:0]  size_sel, off_sel;
    logic [3:0]  be;
    logic [31:0] wdata_rep, rdata_shift;
    logic        misaligned;
    logic        unused_f3;

    // Signedness is applied by the downstream extension stage.
    assign unused_f3 = iv_funct3[2];

    // In IDLE the checker looks at the incoming request, otherwise
    // at the captured one that is on the bus.
    assign size_sel = (state == ST_IDLE) ? iv_funct3[1:0] : size_q;
    assign off_sel  = (state == ST_IDLE) ? iv_addr[1:0]   : addr_q[1:0];

    lsu_align u_align (
        .size        (size_sel),
        .offset      (off_sel),
        .wdata       (wdata_q),
        .rdata       (iv_mem_rdata),
        .be          (be),
        .wdata_rep   (wdata_rep),
        .misaligned  (misaligned),
        .rdata_shift (rdata_shift)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CLW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW  = (CLW > 8) ? CLW : 8;
    logic [CW-1:0] wd_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_cnt <= '0;
        end else if (state == ST_REQ || state == ST_WAIT_RD) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign timeout_hit = (state == ST_REQ || state == ST_WAIT_RD)
                       && (wd_cnt == CW'(TIMEOUT_CYCLES));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (i_req) state_n = misaligned ? ST_RESP : ST_REQ;
            end
            ST_REQ: begin
                if (timeout_hit)    state_n = ST_RESP;
                else if (i_mem_gnt) state_n = we_q ? ST_RESP : ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                if (timeout_hit || i_mem_rvalid) state_n = ST_RESP;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            to_q        <= 1'b0;
            load_word_q <= '0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && i_req) begin
                addr_q  <= iv_addr;
                wdata_q <= iv_wdata;
                size_q  <= iv_funct3[1:0];
                we_q    <= i_we;
                err_q   <= misaligned;
                to_q    <= 1'b0;
            end
            if (timeout_hit) begin
                to_q <= 1'b1;
            end else if (state == ST_WAIT_RD && i_mem_rvalid) begin
                load_word_q <= rdata_shift;
            end
        end
    end

    assign req_on       = (state == ST_REQ) && !timeout_hit;
    assign o_mem_req    = req_on;
    assign ov_mem_addr  = req_on ? {addr_q[31:2], 2'b00} : 32'h0;
    assign ov_mem_be    = req_on ? be : 4'b0000;
    assign ov_mem_wdata = req_on ? wdata_rep : 32'h0;
    assign o_mem_we     = req_on & we_q;

    assign o_busy       = (state != ST_IDLE);
    assign o_ack        = (state == ST_RESP);
    assign o_load_valid = o_ack & ~we_q & ~err_q & ~to_q;
    assign o_misaligned = o_ack & err_q;
    assign o_bus_err    = o_ack & to_q;
    assign ov_load_word = load_word_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed scoreboard bench for lsu_mem_ctrl with a reactive memory model.
// Define LSU_TIMEOUT_EN for the watchdog build (TIMEOUT_CYCLES=8).
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    localparam int TO = 8;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [31:0] iv_addr = '0;
    logic [2:0]  iv_funct3 = '0;
    logic [31:0] iv_wdata = '0;
    logic        o_ack, o_load_valid, o_misaligned, o_bus_err, o_busy;
    logic [31:0] ov_load_word;
    logic        o_mem_req, o_mem_we;
    logic [31:0] ov_mem_addr, ov_mem_wdata;
    logic [3:0]  ov_mem_be;
    logic        i_mem_gnt = 1'b0;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] iv_mem_rdata = '0;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req        (i_req),
        .i_we         (i_we),
        .iv_addr      (iv_addr),
        .iv_funct3    (iv_funct3),
        .iv_wdata     (iv_wdata),
        .o_ack        (o_ack),
        .o_load_valid (o_load_valid),
        .ov_load_word (ov_load_word),
        .o_misaligned (o_misaligned),
        .o_bus_err    (o_bus_err),
        .o_busy       (o_busy),
        .o_mem_req    (o_mem_req),
        .ov_mem_addr  (ov_mem_addr),
        .ov_mem_be    (ov_mem_be),
        .ov_mem_wdata (ov_mem_wdata),
        .o_mem_we     (o_mem_we),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .iv_mem_rdata (iv_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        misal;
        logic        lv;
        logic        berr;
        logic [31:0] word;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] last_word = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic do_op(input string tag, input logic we,
                         input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int gwait);
        exp_t        e;
        logic [1:0]  sz;
        logic [1:0]  off;
        int          nb;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] eword;
        int          gw;
        int          cyc;
        bit          done;
        bit          rd_pend;
        sz  = f3[1:0];
        off = addr[1:0];
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        ebe = '0;
        ewd = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= int'(off) && i < int'(off) + nb) ebe[i] = 1'b1;
            ewd[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        eword = '0;
        for (int i = 0; i < 4; i++)
            if (i + int'(off) < 4) eword[8*i +: 8] = rd[8*(i+int'(off)) +: 8];
        e.misal = (sz == 2'd3) || (sz == 2'd1 && off[0])
               || (sz == 2'd2 && off != 2'd0);
        e.berr = 1'b0;
        e.lv   = !e.misal && !we;
        e.lat  = e.misal ? 1 : (we ? 2 + gwait : 3 + gwait);
        if (gwait > 50) begin
            e.berr = 1'b1;
            e.lv   = 1'b0;
            e.lat  = TO + 2;
        end
        if (e.lv) last_word = eword;
        e.word = last_word;
        sbq.push_back(e);

        i_req     = 1'b1;
        i_we      = we;
        iv_addr   = addr;
        iv_funct3 = f3;
        iv_wdata  = wd;
        gw        = gwait;
        cyc       = 0;
        done      = 0;
        rd_pend   = 0;
        while (!done && cyc < 200) begin
            @(posedge i_clk);
            cyc++;
            @(negedge i_clk);
            i_mem_gnt    = 1'b0;
            i_mem_rvalid = 1'b0;
            if (o_ack) begin
                exp_t x;
                x = sbq.pop_front();
                chk({tag, " latency"}, cyc, x.lat);
                chk({tag, " misaligned"}, o_misaligned, x.misal);
                chk({tag, " load_valid"}, o_load_valid, x.lv);
                chk({tag, " bus_err"}, o_bus_err, x.berr);
                chk({tag, " load_word"}, ov_load_word, x.word);
                chk({tag, " busy"}, o_busy, 1'b1);
                i_req = 1'b0;
                done  = 1;
            end else if (o_mem_req) begin
                chk({tag, " req_expected"}, e.misal, 1'b0);
                chk({tag, " mem_addr"}, ov_mem_addr, {addr[31:2], 2'b00});
                chk({tag, " mem_be"}, ov_mem_be, ebe);
                if (we) chk({tag, " mem_wdata"}, ov_mem_wdata, ewd);
                chk({tag, " mem_we"}, o_mem_we, we);
                if (gw == 0) begin
                    i_mem_gnt = 1'b1;
                    rd_pend   = !we;
                end else begin
                    gw--;
                end
            end else if (rd_pend) begin
                i_mem_rvalid = 1'b1;
                iv_mem_rdata = rd;
                rd_pend      = 0;
            end
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $error("FAIL %s ack_timeout: observed none expected ack", tag);
            void'(sbq.pop_front());
            i_req = 1'b0;
        end
        @(posedge i_clk);
        @(negedge i_clk);
        chk({tag, " idle_after"}, o_busy, 1'b0);
    endtask

    initial begin
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("rst ack", o_ack, 1'b0);
        chk("rst busy", o_busy, 1'b0);
        chk("rst mem_req", o_mem_req, 1'b0);
        chk("rst mem_addr", ov_mem_addr, 32'h0);
        chk("rst mem_be", ov_mem_be, 4'h0);
        chk("rst mem_wdata", ov_mem_wdata, 32'h0);
        chk("rst mem_we", o_mem_we, 1'b0);
        chk("rst load_valid", o_load_valid, 1'b0);
        chk("rst load_word", ov_load_word, 32'h0);
        chk("rst misaligned", o_misaligned, 1'b0);
        chk("rst bus_err", o_bus_err, 1'b0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        do_op("sb_1003", 1'b1, 32'h1003, 3'b000, 32'h0000_00A5, 32'h0, 0);
        do_op("lh_2002", 1'b0, 32'h2002, F3_LH, 32'h0, 32'hBEEF_1234, 0);
        do_op("lw_3001", 1'b0, 32'h3001, F3_LW, 32'h0, 32'h0, 0);
        do_op("lh_3001", 1'b0, 32'h3001, F3_LH, 32'h0, 32'h0, 0);
        do_op("lb_3001", 1'b0, 32'h3001, F3_LB, 32'h0, 32'h1122_3344, 0);
        do_op("lbu_3001", 1'b0, 32'h3001, F3_LBU, 32'h0, 32'hAABB_CCDD, 0);
        do_op("sh_2006", 1'b1, 32'h2006, 3'b001, 32'h1234_ABCD, 32'h0, 0);
        do_op("sw_4000", 1'b1, 32'h4000, 3'b010, 32'hDEAD_BEEF, 32'h0, 0);
        do_op("lw_gnt5", 1'b0, 32'h5000, F3_LW, 32'h0, 32'hCAFE_F00D, 5);
        do_op("sz11_6000", 1'b0, 32'h6000, 3'b011, 32'h0, 32'h0, 0);
        do_op("lhu_7000", 1'b0, 32'h7000, F3_LHU, 32'h0, 32'h89AB_CDEF, 0);
        do_op("sb_gnt2", 1'b1, 32'h7002, 3'b000, 32'h0000_0042, 32'h0, 2);

`ifdef LSU_TIMEOUT_EN
        do_op("lw_timeout", 1'b0, 32'h8000, F3_LW, 32'h0, 32'h0, 1000);
`else
        i_req     = 1'b1;
        i_we      = 1'b0;
        iv_addr   = 32'h8000;
        iv_funct3 = F3_LW;
        repeat (2) @(negedge i_clk);
        for (int i = 0; i < 100; i++) begin
            chk("nogrant ack", o_ack, 1'b0);
            chk("nogrant mem_req", o_mem_req, 1'b1);
            @(negedge i_clk);
        end
        i_req   = 1'b0;
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n   = 1'b1;
        last_word = '0;
        @(negedge i_clk);
        chk("nogrant post_rst busy", o_busy, 1'b0);
`endif

        do_op("lw_9000", 1'b0, 32'h9000, F3_LW, 32'h0, 32'h5A5A_1234, 0);
        i_req     = 1'b1;
        i_we      = 1'b0;
        iv_addr   = 32'hA000;
        iv_funct3 = F3_LW;
        @(negedge i_clk);
        chk("rstwait mem_req", o_mem_req, 1'b1);
        i_mem_gnt = 1'b1;
        @(negedge i_clk);
        i_mem_gnt = 1'b0;
        chk("rstwait busy", o_busy, 1'b1);
        chk("rstwait word_before", ov_load_word, 32'h5A5A_1234);
        i_rst_n = 1'b0;
        i_req   = 1'b0;
        #1;
        chk("rstwait busy0", o_busy, 1'b0);
        chk("rstwait word0", ov_load_word, 32'h0);
        chk("rstwait ack0", o_ack, 1'b0);
        @(negedge i_clk);
        i_rst_n      = 1'b1;
        i_mem_rvalid = 1'b1;
        iv_mem_rdata = 32'hFFFF_FFFF;
        @(negedge i_clk);
        i_mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stale ack", o_ack, 1'b0);
            chk("stale load_valid", o_load_valid, 1'b0);
            chk("stale word", ov_load_word, 32'h0);
            chk("stale busy", o_busy, 1'b0);
            chk("stale mem_req", o_mem_req, 1'b0);
            @(negedge i_clk);
        end
        last_word = '0;

        do_op("lb_b003", 1'b0, 32'hB003, F3_LB, 32'h0, 32'h8877_6655, 0);
        chk("sb_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store memory controller sitting directly upstream of the load width/sign-extension stage in the RV32I MEM stage. Accepts one load or store from the pipeline and generates word-aligned address, byte enables and lane-replicated store data. Runs a req/gnt/rvalid handshake with data memory. For loads, returns the addressed byte/half/word right-justified at bit 0, unextended, for the downstream extension stage.

Parameters:
TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with LSU_TIMEOUT_EN.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_req  in  1  pipeline request; held stable until o_ack
i_we  in  1  1=store, 0=load
iv_addr  in  32  byte address
iv_funct3  in  3  instr[14:12]; [1:0] is size (00 B, 01 H, 10 W)
iv_wdata  in  32  store data, right-justified
o_ack  out  1  one-cycle completion pulse
o_load_valid  out  1  one-cycle pulse; ov_load_word is valid
ov_load_word  out  32  shifted load data to the extension stage
o_misaligned  out  1  one-cycle pulse with o_ack on alignment/size error
o_bus_err  out  1  one-cycle pulse with o_ack on timeout
o_busy  out  1  state != IDLE
o_mem_req  out  1  memory request
ov_mem_addr  out  32  {addr[31:2],2'b00}
ov_mem_be  out  4  byte enables
ov_mem_wdata  out  32  lane-replicated store data
o_mem_we  out  1  memory write
i_mem_gnt  in  1  request accepted
i_mem_rvalid  in  1  read data valid
iv_mem_rdata  in  32  read data

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all outputs 0; ov_load_word=0; captured request registers cleared. Reset mid-transaction abandons it silently, with no ack.
- FSM states: IDLE, REQ, WAIT_RD, RESP.
- IDLE:
  - i_req=1 captures addr, we, funct3 and wdata.
  - Misaligned request goes to RESP with err flag set. Misaligned means H with addr[0]=1, W with addr[1:0]!=0, or size 11.
  - Otherwise goes to REQ.
- REQ:
  - o_mem_req=1; addr, be, wdata and we are driven from the captured registers and held constant until gnt.
  - gnt & we goes to RESP.
  - gnt & ~we goes to WAIT_RD.
- WAIT_RD:
  - o_mem_req=0.
  - On i_mem_rvalid, ov_load_word <= iv_mem_rdata >> (8*addr[1:0]), zero-filled; then go to RESP.
  - rvalid in any other state is ignored. rvalid is never in the same cycle as gnt.
- RESP:
  - o_ack=1.
  - o_load_valid = ~we & ~err & ~timeout.
  - o_misaligned = err.
  - Then go to IDLE. i_req is ignored in RESP.
- Byte enables:
  - B: 4'b0001<<addr[1:0]
  - H: 4'b0011<<addr[1:0]
  - W: 4'b1111
  - Enables are driven for loads too.
- Store data:
  - B: {4{wdata[7:0]}}
  - H: {2{wdata[15:0]}}
  - W: wdata
- funct3[2] (unsigned) has no effect here; extension is downstream.
- Latency, zero-wait memory (gnt in REQ, rvalid next cycle):
  - Store: ack on 3rd cycle after i_req sampled.
  - Load: ack on 4th cycle.
  - Minimum spacing between requests is 3/4 cycles.
- ov_load_word holds its value until the next successful load.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined: an 8+-bit counter clears on entering REQ and increments each cycle in REQ/WAIT_RD. When it reaches TIMEOUT_CYCLES, o_mem_req drops and the FSM goes to RESP with o_bus_err=1 and o_load_valid=0. A late rvalid is ignored.
- Undefined: no counter; the FSM waits indefinitely; o_bus_err is tied to 0.

Decomposition:
- Package lsu_pkg:
  - state encoding (2-bit: IDLE, REQ, WAIT_RD, RESP)
  - size constants SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10
  - load/store funct3 constants (LB 000, LH 001, LW 010, LBU 100, LHU 101)
- Sub-module lsu_align, combinational: size/offset to be, wdata replication, misaligned flag, read-data right shift.
- FSM and registers stay in lsu_mem_ctrl.

Test Plan:
- SB, addr=0x1003, wdata=0x000000A5, gnt in REQ -> mem_addr=0x1000, be=4'b1000, mem_wdata=0xA5A5A5A5, we=1, ack on cycle 3, load_valid=0.
- LH, addr=0x2002, rdata=0xBEEF1234, rvalid cycle after gnt -> be=4'b1100, ov_load_word=0x0000BEEF, load_valid and ack on cycle 4.
- LW, addr=0x3001 -> no mem_req, o_misaligned=1 with ack on cycle 2. Also LH at 0x3001 misaligned; LB/LBU at 0x3001 accepted.
- Load with gnt held low 5 cycles -> mem_req stays 1 with addr/be stable the whole time; then normal completion.
- Reset asserted in WAIT_RD, then a stale rvalid after release -> IDLE, no ack, all outputs 0, ov_load_word=0.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=8 and gnt never asserted -> req drops, ack+o_bus_err after 8 cycles. Without the macro -> still waiting after 100 cycles.
